// File: rtl/conv_regs_sched_if.sv
// Handshake and bank-port bundle for the conversion register access scheduler.
// The slave view is the scheduler; the master view is requesters plus the bank.
interface conv_regs_sched_if;
   logic        FRAME_ACTIVE;
   logic        REQ0_VALID;
   logic [1:0]  REQ0_ADD;
   logic [15:0] REQ0_DAT;
   logic        REQ0_READY;
   logic        REQ1_VALID;
   logic [1:0]  REQ1_ADD;
   logic [15:0] REQ1_DAT;
   logic        REQ1_READY;
   logic        RD_REQ;
   logic [1:0]  RD_ADD;
   logic        RD_READY;
   logic        RD_VALID;
   logic [15:0] RD_DATA;
   logic        WE_A;
   logic [2:0]  ADD_A;
   logic [7:0]  DAT_A;
   logic        RE_B;
   logic [1:0]  ADD_B;
   logic [15:0] DAT_B;
   logic        WR_DONE;
   logic        WR_DONE_ID;
   logic        BUSY;

   modport slave (
      input  FRAME_ACTIVE,
      input  REQ0_VALID, REQ0_ADD, REQ0_DAT,
      output REQ0_READY,
      input  REQ1_VALID, REQ1_ADD, REQ1_DAT,
      output REQ1_READY,
      input  RD_REQ, RD_ADD,
      output RD_READY, RD_VALID, RD_DATA,
      output WE_A, ADD_A, DAT_A,
      output RE_B, ADD_B,
      input  DAT_B,
      output WR_DONE, WR_DONE_ID, BUSY
   );

   modport master (
      output FRAME_ACTIVE,
      output REQ0_VALID, REQ0_ADD, REQ0_DAT,
      input  REQ0_READY,
      output REQ1_VALID, REQ1_ADD, REQ1_DAT,
      input  REQ1_READY,
      output RD_REQ, RD_ADD,
      input  RD_READY, RD_VALID, RD_DATA,
      input  WE_A, ADD_A, DAT_A,
      input  RE_B, ADD_B,
      output DAT_B,
      input  WR_DONE, WR_DONE_ID, BUSY
   );
endinterface

// File: rtl/conv_regs_sched.sv
// Round-robin word-write / single-reader scheduler for the 4-word conversion
// register bank; each word write becomes a high-byte then low-byte bank write.
module conv_regs_sched #(
   parameter bit FRAME_HOLD    = 1'b1,
   parameter bit READ_PRIORITY = 1'b1
) (
   input logic                CLOCK,
   input logic                RESET,
   conv_regs_sched_if.slave   bus
);
   typedef enum logic [2:0] {IDLE, WR_H, WR_L, RD_ISSUE, RD_WAIT} state_t;

   state_t      state, state_nxt;
   logic        last_id;
   logic        wr_id;
   logic [1:0]  wr_add;
   logic [15:0] wr_dat;
   logic [1:0]  rd_add;

   logic        wr_elig, any_wr, rd_ok, win_id, grant_wr, grant_rd;

   always_comb begin
      state_nxt = state;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      win_id    = 1'b0;
      wr_elig   = (state == IDLE) && !RESET && (!FRAME_HOLD || !bus.FRAME_ACTIVE);
      any_wr    = wr_elig && (bus.REQ0_VALID || bus.REQ1_VALID);
      rd_ok     = (state == IDLE) && !RESET && bus.RD_REQ;

      // On a tie the requester that was not granted last wins.
      if (bus.REQ0_VALID && bus.REQ1_VALID) win_id = ~last_id;
      else                                  win_id = bus.REQ1_VALID;

      if (READ_PRIORITY) begin
         grant_rd = rd_ok;
         grant_wr = any_wr && !rd_ok;
      end else begin
         grant_wr = any_wr;
         grant_rd = rd_ok && !any_wr;
      end

      case (state)
         IDLE: begin
            if (grant_wr)      state_nxt = WR_H;
            else if (grant_rd) state_nxt = RD_ISSUE;
         end
         WR_H:     state_nxt = WR_L;
         WR_L:     state_nxt = IDLE;
         RD_ISSUE: state_nxt = RD_WAIT;
         RD_WAIT:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase

      bus.REQ0_READY = grant_wr && !win_id;
      bus.REQ1_READY = grant_wr && win_id;
      bus.RD_READY   = grant_rd;

      bus.WE_A       = 1'b0;
      bus.ADD_A      = 3'd0;
      bus.DAT_A      = 8'd0;
      bus.WR_DONE    = 1'b0;
      bus.WR_DONE_ID = 1'b0;
      bus.RE_B       = 1'b0;
      bus.ADD_B      = 2'd0;
      bus.RD_VALID   = 1'b0;
      bus.RD_DATA    = 16'd0;
      bus.BUSY       = (state != IDLE);

      case (state)
         WR_H: begin
            bus.WE_A  = 1'b1;
            bus.ADD_A = {wr_add, 1'b0};
            bus.DAT_A = wr_dat[15:8];
         end
         WR_L: begin
            // Bank commits the word on the low byte, so completion is signalled here.
            bus.WE_A       = 1'b1;
            bus.ADD_A      = {wr_add, 1'b1};
            bus.DAT_A      = wr_dat[7:0];
            bus.WR_DONE    = 1'b1;
            bus.WR_DONE_ID = wr_id;
         end
         RD_ISSUE: begin
            bus.RE_B  = 1'b1;
            bus.ADD_B = rd_add;
         end
         RD_WAIT: begin
            bus.RD_VALID = 1'b1;
            bus.RD_DATA  = bus.DAT_B;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state   <= IDLE;
         last_id <= 1'b1;
         wr_id   <= 1'b0;
         wr_add  <= 2'd0;
         wr_dat  <= 16'd0;
         rd_add  <= 2'd0;
      end else begin
         state <= state_nxt;
         if (grant_wr) begin
            last_id <= win_id;
            wr_id   <= win_id;
            wr_add  <= win_id ? bus.REQ1_ADD : bus.REQ0_ADD;
            wr_dat  <= win_id ? bus.REQ1_DAT : bus.REQ0_DAT;
         end
         if (grant_rd) rd_add <= bus.RD_ADD;
      end
   end
endmodule

// File: tb/tb_conv_regs_sched.sv
// Directed bench for conv_regs_sched with a behavioural byte-pair register bank.
module tb_conv_regs_sched;
   logic CLOCK = 1'b0;
   logic RESET = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   conv_regs_sched_if bus();

   conv_regs_sched #(.FRAME_HOLD(1'b1), .READ_PRIORITY(1'b1)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   // Bank model: high byte is staged, the word commits on the low-byte write.
   logic [15:0] words [0:3] = '{16'h39a6, 16'h6a58, 16'h0000, 16'h0000};
   logic [7:0]  hi_stage = 8'h00;
   logic [15:0] dat_b_q  = 16'h0000;

   always @(posedge CLOCK) begin
      if (bus.WE_A && !bus.ADD_A[0]) hi_stage <= bus.DAT_A;
      if (bus.WE_A && bus.ADD_A[0])  words[bus.ADD_A[2:1]] <= {hi_stage, bus.DAT_A};
      if (bus.RE_B)                  dat_b_q <= words[bus.ADD_B];
   end
   assign bus.DAT_B = dat_b_q;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic smp();
      @(negedge CLOCK);
   endtask

   task automatic do_read(input logic [1:0] a, input logic [15:0] exp);
      nxt(); bus.RD_REQ = 1'b1; bus.RD_ADD = a; smp();
      chk("rd_ready", bus.RD_READY, 1);
      nxt(); bus.RD_REQ = 1'b0; smp();
      chk("rd_re_b", bus.RE_B, 1);
      chk("rd_add_b", bus.ADD_B, a);
      nxt(); smp();
      chk("rd_valid", bus.RD_VALID, 1);
      chk("rd_data", bus.RD_DATA, exp);
      nxt(); smp();
      chk("rd_valid_end", bus.RD_VALID, 0);
      chk("rd_data_end", bus.RD_DATA, 0);
   endtask

   initial begin
      bus.FRAME_ACTIVE = 1'b0;
      bus.REQ0_VALID = 1'b1; bus.REQ0_ADD = 2'd2; bus.REQ0_DAT = 16'hA55A;
      bus.REQ1_VALID = 1'b0; bus.REQ1_ADD = 2'd0; bus.REQ1_DAT = 16'h0000;
      bus.RD_REQ = 1'b0; bus.RD_ADD = 2'd0;

      // Reset: no READY even with a request pending.
      nxt(); smp();
      chk("rst_ready0", bus.REQ0_READY, 0);
      chk("rst_we_a", bus.WE_A, 0);
      chk("rst_busy", bus.BUSY, 0);
      chk("rst_rd_valid", bus.RD_VALID, 0);
      nxt(); RESET = 1'b0; bus.REQ0_VALID = 1'b0;

      // Read priority over a pending write, then the write goes through.
      nxt(); bus.RD_REQ = 1'b1; bus.RD_ADD = 2'd1; bus.REQ0_VALID = 1'b1; smp();
      chk("rp_rd_ready", bus.RD_READY, 1);
      chk("rp_req0_ready", bus.REQ0_READY, 0);
      nxt(); bus.RD_REQ = 1'b0; smp();
      chk("rp_re_b", bus.RE_B, 1);
      chk("rp_add_b", bus.ADD_B, 1);
      chk("rp_req0_blk1", bus.REQ0_READY, 0);
      chk("rp_busy", bus.BUSY, 1);
      nxt(); smp();
      chk("rp_rd_valid", bus.RD_VALID, 1);
      chk("rp_rd_data", bus.RD_DATA, 16'h6a58);
      chk("rp_req0_blk2", bus.REQ0_READY, 0);
      nxt(); smp();
      chk("wr_req0_ready", bus.REQ0_READY, 1);
      chk("wr_req1_ready", bus.REQ1_READY, 0);
      nxt(); bus.REQ0_VALID = 1'b0; smp();
      chk("wr_h_we", bus.WE_A, 1);
      chk("wr_h_add", bus.ADD_A, 4);
      chk("wr_h_dat", bus.DAT_A, 8'hA5);
      chk("wr_h_done", bus.WR_DONE, 0);
      nxt(); smp();
      chk("wr_l_we", bus.WE_A, 1);
      chk("wr_l_add", bus.ADD_A, 5);
      chk("wr_l_dat", bus.DAT_A, 8'h5A);
      chk("wr_l_done", bus.WR_DONE, 1);
      chk("wr_l_id", bus.WR_DONE_ID, 0);
      nxt(); smp();
      chk("wr_idle_we", bus.WE_A, 0);
      chk("wr_idle_busy", bus.BUSY, 0);
      do_read(2'd2, 16'hA55A);

      // Reset during the high byte: word 0 must be untouched.
      nxt(); bus.REQ0_VALID = 1'b1; bus.REQ0_ADD = 2'd0; bus.REQ0_DAT = 16'hFFFF; smp();
      chk("rw_req0_ready", bus.REQ0_READY, 1);
      nxt(); bus.REQ0_VALID = 1'b0; RESET = 1'b1; smp();
      chk("rw_wr_h", bus.WE_A, 1);
      nxt(); RESET = 1'b0; smp();
      chk("rw_we_a", bus.WE_A, 0);
      chk("rw_add_a", bus.ADD_A, 0);
      chk("rw_dat_a", bus.DAT_A, 0);
      chk("rw_done", bus.WR_DONE, 0);
      chk("rw_busy", bus.BUSY, 0);
      do_read(2'd0, 16'h39a6);

      // Frame hold: grant blocked while active, released the cycle it falls.
      nxt(); bus.FRAME_ACTIVE = 1'b1; bus.REQ1_VALID = 1'b1; bus.REQ1_ADD = 2'd2;
      bus.REQ1_DAT = 16'h1234; smp();
      chk("fh_blk1", bus.REQ1_READY, 0);
      nxt(); smp();
      chk("fh_blk2", bus.REQ1_READY, 0);
      nxt(); bus.FRAME_ACTIVE = 1'b0; smp();
      chk("fh_release", bus.REQ1_READY, 1);
      nxt(); bus.FRAME_ACTIVE = 1'b1; bus.REQ1_VALID = 1'b0; smp();
      chk("fh_h_add", bus.ADD_A, 4);
      chk("fh_h_dat", bus.DAT_A, 8'h12);
      nxt(); smp();
      chk("fh_l_we", bus.WE_A, 1);
      chk("fh_l_add", bus.ADD_A, 5);
      chk("fh_l_dat", bus.DAT_A, 8'h34);
      chk("fh_l_done", bus.WR_DONE, 1);
      chk("fh_l_id", bus.WR_DONE_ID, 1);
      nxt(); bus.FRAME_ACTIVE = 1'b0;
      do_read(2'd2, 16'h1234);

      // Write then read with the read request waiting behind the write.
      nxt(); bus.REQ0_VALID = 1'b1; bus.REQ0_ADD = 2'd3; bus.REQ0_DAT = 16'hBEEF; smp();
      chk("wtr_req0_ready", bus.REQ0_READY, 1);
      nxt(); bus.REQ0_VALID = 1'b0; bus.RD_REQ = 1'b1; bus.RD_ADD = 2'd3; smp();
      chk("wtr_rd_blk1", bus.RD_READY, 0);
      nxt(); smp();
      chk("wtr_rd_blk2", bus.RD_READY, 0);
      nxt(); smp();
      chk("wtr_rd_ready", bus.RD_READY, 1);
      nxt(); bus.RD_REQ = 1'b0; smp();
      chk("wtr_add_b", bus.ADD_B, 3);
      nxt(); smp();
      chk("wtr_rd_valid", bus.RD_VALID, 1);
      chk("wtr_rd_data", bus.RD_DATA, 16'hBEEF);
      nxt(); smp();
      chk("wtr_rd_valid_end", bus.RD_VALID, 0);

      // Round robin from a fresh pointer: REQ0 wins the first tie.
      nxt(); RESET = 1'b1;
      nxt(); RESET = 1'b0;
      nxt();
      bus.REQ0_VALID = 1'b1; bus.REQ0_ADD = 2'd0; bus.REQ0_DAT = 16'h1111;
      bus.REQ1_VALID = 1'b1; bus.REQ1_ADD = 2'd1; bus.REQ1_DAT = 16'h2222;
      for (int g = 0; g < 4; g++) begin
         logic        id;
         logic [15:0] d;
         id = g[0];
         d  = id ? 16'h2222 : 16'h1111;
         smp();
         chk("rr_ready0", bus.REQ0_READY, !id);
         chk("rr_ready1", bus.REQ1_READY, id);
         nxt(); smp();
         chk("rr_h_add", bus.ADD_A, {1'b0, id, 1'b0});
         chk("rr_h_dat", bus.DAT_A, d[15:8]);
         nxt(); smp();
         chk("rr_done", bus.WR_DONE, 1);
         chk("rr_done_id", bus.WR_DONE_ID, id);
         nxt();
      end
      bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
      do_read(2'd0, 16'h1111);
      do_read(2'd1, 16'h2222);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_regs_sched.md
Name: conv_regs_sched

Overview:
- Access scheduler for the 4-word conversion register bank.
- The bank has an 8-address, byte-wide write port and a 4-address, 16-bit read port.
- Two 16-bit word writers share the write port under round-robin arbitration: host config (REQ0) and auto-calibration (REQ1). Each granted word is serialised into the bank's required high-byte/low-byte pair.
- One reader is sequenced onto the read port. Word writes can be deferred until the frame is inactive.

Parameters:
FRAME_HOLD, 1, 1 = write grants only while FRAME_ACTIVE=0; 0 = ignore FRAME_ACTIVE
READ_PRIORITY, 1, 1 = pending read beats pending writes in IDLE; 0 = writes beat read

Ports:
CLOCK  in  1  48MHz system clock, all logic on posedge
RESET  in  1  synchronous, active-high reset
FRAME_ACTIVE  in  1  high during sensor frame readout
REQ0_VALID  in  1  host word-write request
REQ0_ADD  in  2  host word address
REQ0_DAT  in  16  host word data
REQ0_READY  out  1  host request accepted this cycle
REQ1_VALID  in  1  calibration word-write request
REQ1_ADD  in  2  calibration word address
REQ1_DAT  in  16  calibration word data
REQ1_READY  out  1  calibration request accepted this cycle
RD_REQ  in  1  word read request
RD_ADD  in  2  word read address
RD_READY  out  1  read request accepted this cycle
RD_VALID  out  1  RD_DATA valid, one-cycle pulse
RD_DATA  out  16  read word
WE_A  out  1  bank byte write enable
ADD_A  out  3  bank byte address
DAT_A  out  8  bank byte data
RE_B  out  1  bank read enable
ADD_B  out  2  bank read address
DAT_B  in  16  bank registered read data
WR_DONE  out  1  pulse: word write completed
WR_DONE_ID  out  1  requester of completed word (0/1)
BUSY  out  1  state != IDLE

Behaviour:
- States: IDLE, WR_H, WR_L, RD_ISSUE, RD_WAIT.
- Handshake:
  - READY outputs are combinational from state and VALID/REQ.
  - They may be high only in IDLE, and at most one READY is high per cycle.
  - A request is accepted when VALID and READY are both high; address and data are latched on that edge.
  - Requesters hold VALID, ADD and DAT stable until READY.
- Write eligible: state=IDLE and (FRAME_HOLD=0 or FRAME_ACTIVE=0).
- Arbitration:
  - One requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - Last-grant pointer updates on each write accept; reset value = 1, so REQ0 wins the first tie.
- IDLE priority:
  - READ_PRIORITY=1: RD_REQ wins over writes.
  - READ_PRIORITY=0: an eligible write wins over RD_REQ.
  - RD_REQ is never blocked by FRAME_ACTIVE.
- Write timing (accept at cycle T):
  - T+1 WR_H: WE_A=1, ADD_A={addr,0}, DAT_A=dat[15:8].
  - T+2 WR_L: WE_A=1, ADD_A={addr,1}, DAT_A=dat[7:0]; WR_DONE=1, WR_DONE_ID=winner.
  - T+3 IDLE; a new request may be accepted at T+3.
  - The bank commits the word at the end of T+2.
  - The high and low byte are always on consecutive cycles and no other WE_A intervenes.
  - Word throughput: 1 per 3 cycles.
- Read timing (accept at cycle T):
  - T+1 RD_ISSUE: RE_B=1, ADD_B=addr.
  - T+2 RD_WAIT: RD_VALID=1, RD_DATA=DAT_B (combinational pass-through).
  - T+3 IDLE.
  - A read accepted right after a write returns the new word.
- Outside their states: WE_A=0, RE_B=0, RD_VALID=0, WR_DONE=0.
  - ADD_A, DAT_A, ADD_B and RD_DATA are driven 0 when not active.
- FRAME_ACTIVE rising mid-write (WR_H/WR_L): the pair still completes; only new grants are blocked.
- Reset:
  - All outputs 0, state IDLE, pointer=1, latched fields cleared.
  - Reset in WR_H aborts before the low byte; no partial word is committed, because the bank only commits on the low byte.
  - No READY is asserted while RESET=1.

Test Plan:
- Single write: REQ0_VALID, ADD=2, DAT=16'hA55A, FRAME_ACTIVE=0 -> REQ0_READY at T; WE_A/ADD_A/DAT_A = 1/4/8'hA5 at T+1 and 1/5/8'h5A at T+2; WR_DONE, WR_DONE_ID=0 at T+2; readback of word 2 = 16'hA55A.
- Round-robin: both VALID continuously; REQ0 ADD=0 DAT=16'h1111, REQ1 ADD=1 DAT=16'h2222 -> grants REQ0, REQ1, REQ0, REQ1 at 3-cycle spacing; each WR_DONE_ID matches its grant.
- Frame hold: FRAME_ACTIVE=1, REQ1_VALID -> REQ1_READY stays 0. FRAME_ACTIVE falls -> READY the same cycle. FRAME_ACTIVE raised during WR_H -> WR_L still issued.
- Read priority: RD_REQ ADD=1 with REQ0_VALID in IDLE, READ_PRIORITY=1 -> RD_READY first; RE_B=1, ADD_B=1 at T+1; RD_VALID at T+2 with RD_DATA = bank reset value 16'h6a58; REQ0 granted at T+3.
- Write-then-read: write word 3 = 16'hBEEF, RD_REQ held -> RD_DATA=16'hBEEF, RD_VALID exactly one cycle.
- Reset mid-write: RESET during WR_H of word 0 = 16'hFFFF -> next cycle all outputs 0, BUSY=0; word 0 reads back 16'h39a6.
